// File: rtl/sipo_rx.sv
// sipo_rx: LSB-first serial-to-parallel receiver with a held output word,
// consumer acknowledge, frame resync and a sticky overrun flag.
module sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_en,
  input  logic             sync,
  input  logic             p_ack,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  output logic             busy,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {RX_IDLE = 1'b0, RX_SHIFT = 1'b1} rx_state_e;

  rx_state_e        st_q, st_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pvalid_q, pvalid_d;
  logic             ovf_q, ovf_d;
  logic             word_done;
  logic             ovf_set;

  // Bit 0 of the shift register is the bit falling off the end on each shift;
  // it is never part of a completed word.
  logic unused_sr0;
  assign unused_sr0 = sr_q[0];

  // State register; reset discards partial and held words.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= RX_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      pout_q   <= '0;
      pvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      pout_q   <= pout_d;
      pvalid_q <= pvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state: shift/count, word completion, handshake and overrun.
  always_comb begin
    st_d      = st_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    pout_d    = pout_q;
    pvalid_d  = pvalid_q;
    ovf_d     = ovf_q;
    word_done = 1'b0;
    ovf_set   = 1'b0;

    if (s_en) begin
      sr_d = {s_in, sr_q[WIDTH-1:1]};
      if (sync) begin
        // Restart: this bit becomes bit 0 of a fresh word.
        cnt_d = CNT_ONE;
        st_d  = RX_SHIFT;
      end else if (st_q == RX_IDLE) begin
        cnt_d = CNT_ONE;
        st_d  = RX_SHIFT;
      end else if (cnt_q == CNT_LAST) begin
        word_done = 1'b1;
        cnt_d     = '0;
        st_d      = RX_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (sync) begin
      cnt_d = '0;
      st_d  = RX_IDLE;
    end

    if (word_done) begin
      pout_d   = {s_in, sr_q[WIDTH-1:1]};
      pvalid_d = 1'b1;
      ovf_set  = pvalid_q && !p_ack;
    end else if (p_ack && pvalid_q) begin
      pvalid_d = 1'b0;
    end

    // A new overrun wins over a simultaneous clear.
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  assign p_out   = pout_q;
  assign p_valid = pvalid_q;
  assign busy    = (cnt_q != '0);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: bit-queue reference model compared every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_sipo_rx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, s_in, s_en, sync, p_ack, ovf_clr;
  logic [W-1:0] p_out;
  logic         p_valid, busy, ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit           mq[$];
  logic [W-1:0] m_word;
  logic         m_valid, m_ovf;

  sipo_rx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .s_en(s_en), .sync(sync),
    .p_ack(p_ack), .ovf_clr(ovf_clr),
    .p_out(p_out), .p_valid(p_valid), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model of one clock edge, from the receiver's rules rather than its registers.
  task automatic model_edge(input logic r, si, en, sy, ak, cl);
    logic [W-1:0] w;
    bit done, set;
    if (r) begin
      mq.delete(); m_word = '0; m_valid = 1'b0; m_ovf = 1'b0;
      return;
    end
    done = 0; set = 0; w = '0;
    if (en) begin
      if (sy) mq.delete();
      mq.push_back(si);
      if (mq.size() == W) begin
        for (int i = 0; i < W; i++) w[i] = mq[i];
        mq.delete();
        done = 1;
      end
    end else if (sy) begin
      mq.delete();
    end
    if (done) begin
      if (m_valid && !ak) set = 1;
      m_word = w; m_valid = 1'b1;
    end else if (ak && m_valid) begin
      m_valid = 1'b0;
    end
    if (set) m_ovf = 1'b1;
    else if (cl) m_ovf = 1'b0;
  endtask

  // Drive one cycle, advance the model, then compare outputs after the edge.
  task automatic step(input logic r, si, en, sy, ak, cl);
    rst = r; s_in = si; s_en = en; sync = sy; p_ack = ak; ovf_clr = cl;
    @(posedge clk);
    model_edge(r, si, en, sy, ak, cl);
    #1;
    chk("p_out",   p_out,   m_word);
    chk("p_valid", p_valid, m_valid);
    chk("busy",    busy,    (mq.size() != 0));
    chk("ovf",     ovf,     m_ovf);
  endtask

  task automatic bitc(input logic b);            // one strobed bit
    step(0, b, 1, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Send a word LSB first; optionally acknowledge on the completing cycle.
  task automatic send(input logic [W-1:0] w, input logic ack_last);
    for (int i = 0; i < W - 1; i++) bitc(w[i]);
    step(0, w[W-1], 1, 0, ack_last, 0);
  endtask

  task automatic ack1;
    step(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    rst = 1; s_in = 0; s_en = 0; sync = 0; p_ack = 0; ovf_clr = 0;
    // Reset state
    step(1, 1, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_pout", p_out, 0); chk("rst_valid", p_valid, 0);
    chk("rst_busy", busy, 0);  chk("rst_ovf", ovf, 0);

    // Basic receive 1,0,1,1 -> 4'hD
    bitc(1); chk("b1_busy", busy, 1);
    bitc(0); chk("b2_busy", busy, 1);
    bitc(1); chk("b3_busy", busy, 1); chk("b3_valid", p_valid, 0);
    bitc(1); chk("basic_pout", p_out, 4'hD); chk("basic_valid", p_valid, 1);
    chk("basic_busy", busy, 0);
    ack1; chk("ack_valid", p_valid, 0);

    // Gapped strobes
    bitc(1); idle(3); bitc(0); idle(3); bitc(1); idle(3);
    chk("gap_busy", busy, 1);
    bitc(1); chk("gap_pout", p_out, 4'hD); chk("gap_valid", p_valid, 1);
    idle(2); chk("gap_hold", p_valid, 1);
    ack1; chk("gap_ack_valid", p_valid, 0); chk("gap_ack_pout", p_out, 4'hD);
    ack1; chk("stray_ack", p_valid, 0);

    // Sync restart with s_en: 1,1, sync+0, 0,1,0 -> 4'h4
    bitc(1); bitc(1);
    step(0, 0, 1, 1, 0, 0); chk("sync_busy", busy, 1); chk("sync_novalid", p_valid, 0);
    bitc(0); bitc(1); chk("sync_novalid2", p_valid, 0);
    bitc(0); chk("sync_pout", p_out, 4'h4); chk("sync_valid", p_valid, 1);
    ack1;

    // Sync without s_en mid-word: 1,1, sync, then 1,0,0,0 -> 4'h1
    bitc(1); bitc(1);
    step(0, 0, 0, 1, 0, 0); chk("sync_idle_busy", busy, 0);
    send(4'h1, 0); chk("sync2_pout", p_out, 4'h1);
    ack1;

    // Overrun
    send(4'hA, 0); chk("ovr_a", p_out, 4'hA);
    send(4'h5, 0); chk("ovr_pout", p_out, 4'h5); chk("ovr_valid", p_valid, 1);
    chk("ovr_flag", ovf, 1);
    idle(1); chk("ovr_sticky", ovf, 1);
    step(0, 0, 0, 0, 0, 1); chk("ovr_clr", ovf, 0);
    send(4'hA, 1); chk("ack_cmp_pout", p_out, 4'hA); chk("ack_cmp_valid", p_valid, 1);
    chk("ack_cmp_ovf", ovf, 0);
    // Set and clear in the same cycle: set wins
    for (int i = 0; i < W - 1; i++) bitc(1'b1);
    step(0, 1, 1, 0, 0, 1); chk("set_wins", ovf, 1); chk("set_wins_pout", p_out, 4'hF);
    step(0, 0, 0, 0, 1, 1); chk("clr2", ovf, 0); chk("clr2_valid", p_valid, 0);

    // Reset mid-operation with a held 4'h3
    send(4'h3, 0); chk("pre_rst_pout", p_out, 4'h3);
    bitc(1); bitc(0);
    step(1, 1, 1, 0, 0, 0);
    chk("mid_rst_pout", p_out, 0); chk("mid_rst_valid", p_valid, 0);
    chk("mid_rst_busy", busy, 0);  chk("mid_rst_ovf", ovf, 0);
    bitc(0); bitc(1); bitc(1); bitc(0);
    chk("post_rst_pout", p_out, 4'h6); chk("post_rst_valid", p_valid, 1);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
